crc_encoder: RTL and testbench
==============================

// Module: crc_encoder
// PURPOSE
//   Bit-serial CRC generator: appends an (M-1)-bit CRC remainder to an N-bit data word, dividing by a runtime polynomial.
//   Transmit-side counterpart of the CRC error-detection block.
//   Output codeword layout matches the checker input {data, crc}, so the two blocks chain back-to-back.
//   Valid/ready handshake on both sides; one word in flight at a time.
// PARAMETERS
//   N  11  data word width (bits), N >= 2
//   M  5   polynomial width incl. leading 1 (CRC width = M-1), 2 <= M <= N
// PORTS
//   Clk           in   1      clock; all logic on rising edge
//   reset         in   1      synchronous, active-high reset
//   in_valid      in   1      data_in/polynomial valid
//   in_ready      out  1      block can accept a word (high only in IDLE)
//   data_in       in   N      message word, MSB transmitted first
//   polynomial    in   M      generator polynomial, bit M-1 = x^(M-1) term
//   out_valid     out  1      encoded_data valid; held until out_ready
//   out_ready     in   1      downstream accepts encoded_data
//   encoded_data  out  N+M-1  {data, crc}; crc in bits [M-2:0]
//   inject_err    in   1      only when CRC_ERR_INJECT_EN defined (see CONFIGURATION)
// BEHAVIOUR
//   Reset (sync, high): state=IDLE, count=0, in_ready=1, out_valid=0, encoded_data=0, shift reg=0.
//     Reset overrides any handshake in the same cycle; mid-operation reset abandons the word.
//   FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE:  in_ready=1. On edge with in_valid=1, latch data_in, latch polynomial,
//          load shift reg sr[N+M-2:0] = {data_in, (M-1)'b0}, count=0, go SHIFT.
//   SHIFT: in_ready=0. Each cycle performs one long-division step:
//            if sr[N+M-2]=1: sr = (sr ^ {poly, (N-1)'b0}) << 1, else sr = sr << 1; count++.
//          After exactly N steps (count reaches N), remainder = sr[N+M-2:N] (top M-1 bits).
//          On that same edge, register encoded_data = {latched data, remainder}, assert out_valid, go DONE.
//   Latency: out_valid rises N clock edges after the accepting edge.
//     For N=11, the accept edge is E0 and out_valid is first high after E11.
//   Throughput: one word per N+2 cycles minimum (accept, N shifts, output handshake).
//   DONE:  out_valid=1, encoded_data stable until the edge with out_ready=1.
//          On that edge: out_valid=0, in_ready=1, go IDLE.
//          in_ready stays 0 during DONE, including the handshake cycle.
//   data_in/polynomial changes after accept are ignored (latched copies used).
//   out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
//   All-zero data produces encoded_data=0; it is still presented with out_valid=1.
//   polynomial[M-1]=0 is not rejected; the result is whatever the division step above yields.
//   count width $clog2(N+1); no wrap possible, because count is cleared on every accept.
// CONFIGURATION
//   CRC_ERR_INJECT_EN defined: inject_err port exists and is sampled with the in_valid handshake in IDLE.
//     If inject_err was 1 at accept, encoded_data[0] is inverted in the registered output.
//     This forces a checker failure for system tests.
//   CRC_ERR_INJECT_EN undefined: no inject_err port; encoded_data is always the correct codeword.
// TESTING (N=11, M=5, polynomial=5'b10011 unless noted)
//   1. Reset during SHIFT (cycle 5) -> next cycle out_valid=0, in_ready=1, encoded_data=0.
//      A following word encodes correctly.
//   2. data_in=11'h001 -> after 11 cycles out_valid=1, encoded_data=15'h0013 (crc=4'b0011).
//   3. data_in=11'h400 -> encoded_data=15'h4009 (crc=4'b1001).
//      Hold out_ready=0 for 5 cycles: value and out_valid stay stable, in_ready=0 throughout.
//   4. data_in=0 -> encoded_data=15'h0000, out_valid=1 after 11 cycles.
//      Change polynomial during SHIFT -> result unaffected.
//   5. Loopback: feed 200 random words into the CRC error-detection block -> error_check=0 and final_data==data_in for every word.
//   6. CRC_ERR_INJECT_EN, inject_err=1, data_in=11'h001 -> encoded_data=15'h0012.
//      The checker flags error_check=1.

Source files
------------

// File: rtl/crc_encoder_if.sv
// rtl/crc_encoder_if.sv - handshake bundle for crc_encoder (inject_err present when CRC_ERR_INJECT_EN is defined)
interface crc_encoder_if #(
    parameter int N = 11,
    parameter int M = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     data_in;
    logic [M-1:0]     polynomial;
    logic             out_valid;
    logic             out_ready;
    logic [N+M-2:0]   encoded_data;
`ifdef CRC_ERR_INJECT_EN
    logic             inject_err;

    modport slave (
        input  in_valid, data_in, polynomial, out_ready, inject_err,
        output in_ready, out_valid, encoded_data
    );
    modport master (
        output in_valid, data_in, polynomial, out_ready, inject_err,
        input  in_ready, out_valid, encoded_data
    );
`else
    modport slave (
        input  in_valid, data_in, polynomial, out_ready,
        output in_ready, out_valid, encoded_data
    );
    modport master (
        output in_valid, data_in, polynomial, out_ready,
        input  in_ready, out_valid, encoded_data
    );
`endif
endinterface

// File: rtl/crc_encoder.sv
// rtl/crc_encoder.sv - bit-serial CRC encoder producing {data, crc}; CRC_ERR_INJECT_EN adds a bit-0 error injector
module crc_encoder #(
    parameter int N = 11,
    parameter int M = 5
) (
    input  logic          Clk,
    input  logic          reset,
    crc_encoder_if.slave  bus
);
    localparam int W  = N + M - 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic [W-1:0]    sr;
    logic [W-1:0]    sr_step;
    logic [N-1:0]    data_q;
    logic [M-1:0]    poly_q;
    logic [W-1:0]    enc_q;
    logic            last_step;
`ifdef CRC_ERR_INJECT_EN
    logic            inj_q;
`endif

    // One long-division step: subtract the aligned polynomial when the top bit is set, then shift.
    assign sr_step   = sr[W-1] ? ((sr ^ {poly_q, {(N-1){1'b0}}}) << 1) : (sr << 1);
    assign last_step = (count == CW'(N - 1));
    assign bus.encoded_data = enc_q;

    always_ff @(posedge Clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid)
                    state_next = SHIFT;
            end
            SHIFT: begin
                if (last_step)
                    state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            count  <= '0;
            sr     <= '0;
            data_q <= '0;
            poly_q <= '0;
            enc_q  <= '0;
`ifdef CRC_ERR_INJECT_EN
            inj_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q <= bus.data_in;
                        poly_q <= bus.polynomial;
                        sr     <= {bus.data_in, {(M-1){1'b0}}};
                        count  <= '0;
`ifdef CRC_ERR_INJECT_EN
                        inj_q  <= bus.inject_err;
`endif
                    end
                end
                SHIFT: begin
                    sr    <= sr_step;
                    count <= count + CW'(1);
                    // After the N-th step the remainder sits in the top M-1 bits of the shifted register.
                    if (last_step) begin
`ifdef CRC_ERR_INJECT_EN
                        enc_q <= {data_q, sr_step[W-1:N]} ^ W'(inj_q);
`else
                        enc_q <= {data_q, sr_step[W-1:N]};
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_encoder.sv
// tb/tb_crc_encoder.sv - scoreboard bench for crc_encoder (N=11, M=5), with bench-side CRC checker model
module tb_crc_encoder;
    localparam int N = 11;
    localparam int M = 5;
    localparam int W = N + M - 1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [W-1:0] exp_q[$];

    crc_encoder_if #(.N(N), .M(M)) bus ();

    crc_encoder #(.N(N), .M(M)) dut (
        .Clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // LFSR-form CRC: feeds data MSB first through an (M-1)-bit register.
    function automatic logic [M-2:0] model_crc(input logic [N-1:0] d, input logic [M-1:0] p);
        logic [M-2:0] c;
        logic fb;
        c = '0;
        for (int i = N - 1; i >= 0; i--) begin
            fb = c[M-2] ^ d[i];
            c  = {c[M-3:0], 1'b0};
            if (fb)
                c = c ^ p[M-2:0];
        end
        return c;
    endfunction

    // Receiver-side check: remainder of the whole codeword must be zero.
    function automatic logic [M-2:0] codeword_rem(input logic [W-1:0] cw, input logic [M-1:0] p);
        logic [M-1:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            r = {r[M-2:0], cw[i]};
            if (r[M-1])
                r = r ^ p;
        end
        return r[M-2:0];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input logic [N-1:0] d, input logic [M-1:0] p, input int hold,
                            input bit chg_inputs, input bit use_fixed, input logic [W-1:0] fixed,
                            input bit inj);
        int lat;
        logic [W-1:0] exp_cw;
        logic [W-1:0] held;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.data_in    = d;
        bus.polynomial = p;
        bus.in_valid   = 1'b1;
`ifdef CRC_ERR_INJECT_EN
        bus.inject_err = inj;
`endif
        if (use_fixed)
            exp_q.push_back(fixed);
        else
            exp_q.push_back({d, model_crc(d, p)} ^ W'(inj));
        step();
        bus.in_valid = 1'b0;
`ifdef CRC_ERR_INJECT_EN
        bus.inject_err = 1'b0;
`endif
        if (chg_inputs) begin
            bus.data_in    = ~d;
            bus.polynomial = ~p;
        end
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'd11);
        held = bus.encoded_data;
        for (int i = 0; i < hold; i++) begin
            bus.out_ready = 1'b0;
            step();
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", 32'(bus.encoded_data), 32'(held));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        exp_cw = exp_q.pop_front();
        check("codeword", 32'(bus.encoded_data), 32'(exp_cw));
        check("checker_err", 32'(codeword_rem(bus.encoded_data, p) != '0), 32'(inj));
        check("checker_data", 32'(bus.encoded_data[W-1:M-1]), 32'(d));
        bus.out_ready = 1'b1;
        check("in_ready_handshake", 32'(bus.in_ready), 32'd0);
        step();
        bus.out_ready = 1'b0;
        check("valid_drop", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [N-1:0] rd;
        logic [M-2:0] rp;
        n_checks = 0;
        n_pass   = 0;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.data_in    = '0;
        bus.polynomial = '0;
`ifdef CRC_ERR_INJECT_EN
        bus.inject_err = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_encoded", 32'(bus.encoded_data), 32'd0);

        // Abandon a word with reset partway through the shift phase.
        bus.data_in    = 11'h2AB;
        bus.polynomial = 5'b10011;
        bus.in_valid   = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_encoded", 32'(bus.encoded_data), 32'd0);
        for (int i = 0; i < 12; i++) step();
        check("midrst_quiet", 32'(bus.out_valid), 32'd0);

        run_word(11'h001, 5'b10011, 0, 1'b0, 1'b1, 15'h0013, 1'b0);
        run_word(11'h400, 5'b10011, 5, 1'b0, 1'b1, 15'h4009, 1'b0);
        run_word(11'h000, 5'b10011, 0, 1'b1, 1'b1, 15'h0000, 1'b0);
        run_word(11'h2AB, 5'b10011, 1, 1'b1, 1'b0, '0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            rd = N'($urandom_range(0, (1 << N) - 1));
            rp = (M-1)'($urandom_range(0, (1 << (M-1)) - 1));
            run_word(rd, {1'b1, rp}, int'($urandom_range(0, 2)), k[0], 1'b0, '0, 1'b0);
        end

`ifdef CRC_ERR_INJECT_EN
        run_word(11'h001, 5'b10011, 0, 1'b0, 1'b1, 15'h0012, 1'b1);
        run_word(11'h001, 5'b10011, 0, 1'b0, 1'b1, 15'h0013, 1'b0);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
